// File: rtl/registers_writeback_stage3.sv
// Stage-3 writeback: commits stage-2 write strobes into a 16 x 32 register file,
// serves two read ports and tracks pending writes for hazard stalls. Optional macro: REGS_FORWARD_EN.
module registers_writeback_stage3 #(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write,
    input  logic                  alu_cycle,
    input  logic [IDX_W-1:0]      write_index,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] alu_result_latched,
    input  logic                  write_immediate,
    input  logic [15:0]           write_immediate_data,
    input  logic [1:0]            write_immediate_type,
    input  logic                  issue_valid,
    input  logic [IDX_W-1:0]      issue_index,
    input  logic [IDX_W-1:0]      read_index_a,
    input  logic [IDX_W-1:0]      read_index_b,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b,
    output logic                  hazard,
    output logic [31:0]           retired_writes,
    output logic                  write_conflict
);

    typedef enum logic [1:0] {
        IT_UNSIGNED = 2'd0,
        IT_SIGNED   = 2'd1,
        IT_TOP      = 2'd2,
        IT_BOTTOM   = 2'd3
    } t_immediate_type;

    // Merge a 16-bit immediate into a register value; TOP/BOTTOM keep the other half.
    function automatic logic [DATA_WIDTH-1:0] imm_merge(
        input logic [1:0]            ty,
        input logic [15:0]           imm,
        input logic [DATA_WIDTH-1:0] cur
    );
        logic [DATA_WIDTH-1:0] res;
        case (t_immediate_type'(ty))
            IT_UNSIGNED: res = {{(DATA_WIDTH-16){1'b0}}, imm};
            IT_SIGNED:   res = {{(DATA_WIDTH-16){imm[15]}}, imm};
            IT_TOP:      res = {imm, cur[DATA_WIDTH-17:0]};
            IT_BOTTOM:   res = {cur[DATA_WIDTH-1:16], imm};
            default:     res = {{(DATA_WIDTH-16){1'b0}}, imm};
        endcase
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_r;
    logic [31:0]           retired_writes_r;
    logic                  write_conflict_r;

    logic                  commit_s;
    logic [DATA_WIDTH-1:0] commit_data_s;
    logic [NUM_REGS-1:0]   clear_mask_s;
    logic [NUM_REGS-1:0]   set_mask_s;
    logic [NUM_REGS-1:0]   pending_next_s;
    logic [NUM_REGS-1:0]   visible_pending_s;

    // Commit value selection; the full-word write always wins over an immediate.
    always_comb begin
        commit_s      = write | write_immediate;
        commit_data_s = '0;
        if (write) begin
            commit_data_s = alu_cycle ? alu_result_latched : write_data;
        end else if (write_immediate) begin
            commit_data_s = imm_merge(write_immediate_type, write_immediate_data,
                                      regs_r[write_index]);
        end else begin
            commit_data_s = '0;
        end
    end

    // Scoreboard next state: issue set is applied after commit clear so set wins.
    always_comb begin
        clear_mask_s = '0;
        set_mask_s   = '0;
        if (commit_s) begin
            clear_mask_s[write_index] = 1'b1;
        end else begin
            clear_mask_s = '0;
        end
        if (issue_valid) begin
            set_mask_s[issue_index] = 1'b1;
        end else begin
            set_mask_s = '0;
        end
        pending_next_s = (pending_r & ~clear_mask_s) | set_mask_s;
    end

    // Read ports and hazard, with optional same-cycle bypass of the commit.
    always_comb begin
`ifdef REGS_FORWARD_EN
        visible_pending_s = pending_r & ~(clear_mask_s & ~set_mask_s);
        if (commit_s && (read_index_a == write_index)) begin
            read_data_a = commit_data_s;
        end else begin
            read_data_a = regs_r[read_index_a];
        end
        if (commit_s && (read_index_b == write_index)) begin
            read_data_b = commit_data_s;
        end else begin
            read_data_b = regs_r[read_index_b];
        end
`else
        visible_pending_s = pending_r;
        read_data_a       = regs_r[read_index_a];
        read_data_b       = regs_r[read_index_b];
`endif
        hazard = visible_pending_s[read_index_a] | visible_pending_s[read_index_b];
    end

    // Register file, scoreboard, retire counter and sticky conflict flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
            pending_r        <= '0;
            retired_writes_r <= 32'd0;
            write_conflict_r <= 1'b0;
        end else begin
            if (commit_s) begin
                regs_r[write_index] <= commit_data_s;
                retired_writes_r    <= retired_writes_r + 32'd1;
            end
            if (write && write_immediate) begin
                write_conflict_r <= 1'b1;
            end
            pending_r <= pending_next_s;
        end
    end

    assign retired_writes = retired_writes_r;
    assign write_conflict = write_conflict_r;

endmodule

// File: tb/tb_registers_writeback_stage3.sv
// Randomized and directed bench for registers_writeback_stage3 against a behavioural model.
module tb_registers_writeback_stage3;

    logic        clock;
    logic        reset;
    logic        write;
    logic        alu_cycle;
    logic [3:0]  write_index;
    logic [31:0] write_data;
    logic [31:0] alu_result_latched;
    logic        write_immediate;
    logic [15:0] write_immediate_data;
    logic [1:0]  write_immediate_type;
    logic        issue_valid;
    logic [3:0]  issue_index;
    logic [3:0]  read_index_a;
    logic [3:0]  read_index_b;
    logic [31:0] read_data_a;
    logic [31:0] read_data_b;
    logic        hazard;
    logic [31:0] retired_writes;
    logic        write_conflict;

    registers_writeback_stage3 dut (
        .clock(clock), .reset(reset), .write(write), .alu_cycle(alu_cycle),
        .write_index(write_index), .write_data(write_data),
        .alu_result_latched(alu_result_latched), .write_immediate(write_immediate),
        .write_immediate_data(write_immediate_data),
        .write_immediate_type(write_immediate_type), .issue_valid(issue_valid),
        .issue_index(issue_index), .read_index_a(read_index_a),
        .read_index_b(read_index_b), .read_data_a(read_data_a),
        .read_data_b(read_data_b), .hazard(hazard),
        .retired_writes(retired_writes), .write_conflict(write_conflict)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int tests_run;
    int tests_failed;

    logic [31:0] m_regs [16];
    bit          m_pending [16];
    logic [31:0] m_retired;
    bit          m_conflict;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_commit_value();
        logic [31:0] imm32;
        logic [31:0] cur;
        imm32 = {16'h0000, write_immediate_data};
        cur   = m_regs[write_index];
        if (write) return alu_cycle ? alu_result_latched : write_data;
        case (write_immediate_type)
            2'd0:    return imm32;
            2'd1:    return (imm32 >= 32'h0000_8000) ? imm32 + 32'hFFFF_0000 : imm32;
            2'd2:    return imm32 * 32'd65536 + (cur % 32'd65536);
            default: return (cur / 32'd65536) * 32'd65536 + imm32;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] idx);
`ifdef REGS_FORWARD_EN
        if ((write || write_immediate) && idx == write_index) return m_commit_value();
`endif
        return m_regs[idx];
    endfunction

    function automatic bit m_pending_seen(input logic [3:0] idx);
`ifdef REGS_FORWARD_EN
        if ((write || write_immediate) && idx == write_index &&
            !(issue_valid && issue_index == idx)) return 1'b0;
`endif
        return m_pending[idx];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_regs[i]    = 32'd0;
            m_pending[i] = 1'b0;
        end
        m_retired  = 32'd0;
        m_conflict = 1'b0;
    endtask

    task automatic m_update();
        logic [31:0] v;
        if (reset) begin
            m_reset();
        end else begin
            if (write || write_immediate) begin
                v = m_commit_value();
                m_regs[write_index]    = v;
                m_pending[write_index] = 1'b0;
                m_retired              = m_retired + 32'd1;
            end
            if (write && write_immediate) m_conflict = 1'b1;
            if (issue_valid) m_pending[issue_index] = 1'b1;
        end
    endtask

    task automatic idle();
        write = 1'b0; alu_cycle = 1'b0; write_index = 4'd0;
        write_data = 32'd0; alu_result_latched = 32'd0;
        write_immediate = 1'b0; write_immediate_data = 16'd0; write_immediate_type = 2'd0;
        issue_valid = 1'b0; issue_index = 4'd0;
    endtask

    // Inputs are set while clock is low; checks outputs, clocks once, updates the model.
    task automatic tick();
        #1;
        check("read_a", read_data_a, m_read(read_index_a));
        check("read_b", read_data_b, m_read(read_index_b));
        check("hazard", {31'd0, hazard},
              {31'd0, m_pending_seen(read_index_a) | m_pending_seen(read_index_b)});
        check("retired", retired_writes, m_retired);
        check("conflict", {31'd0, write_conflict}, {31'd0, m_conflict});
        @(posedge clock);
        m_update();
        @(negedge clock);
        idle();
    endtask

    task automatic read_check(input string tag, input logic [3:0] idx, input logic [31:0] exp);
        read_index_a = idx;
        #1;
        check(tag, read_data_a, exp);
    endtask

    task automatic do_imm(input logic [3:0] idx, input logic [1:0] ty, input logic [15:0] imm);
        write_immediate = 1'b1; write_index = idx;
        write_immediate_type = ty; write_immediate_data = imm;
        tick();
    endtask

    task automatic do_write(input logic [3:0] idx, input logic alu, input logic [31:0] d,
                            input logic [31:0] a);
        write = 1'b1; write_index = idx; alu_cycle = alu;
        write_data = d; alu_result_latched = a;
        tick();
    endtask

    initial begin
        logic [31:0] prev;
        tests_run = 0;
        tests_failed = 0;
        idle();
        read_index_a = 4'd0;
        read_index_b = 4'd0;
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        m_reset();

        for (int r = 0; r < 16; r++) read_check("reset_reg", 4'(r), 32'd0);
        check("reset_hazard", {31'd0, hazard}, 32'd0);
        check("reset_retired", retired_writes, 32'd0);

        do_imm(4'd3, 2'd1, 16'h8001);
        read_check("imm_signed", 4'd3, 32'hFFFF_8001);
        do_imm(4'd3, 2'd0, 16'h8001);
        read_check("imm_unsigned", 4'd3, 32'h0000_8001);

        do_write(4'd5, 1'b0, 32'h1234_5678, 32'd0);
        do_imm(4'd5, 2'd2, 16'hABCD);
        read_check("imm_top", 4'd5, 32'hABCD_5678);
        do_imm(4'd5, 2'd3, 16'h0042);
        read_check("imm_bottom", 4'd5, 32'hABCD_0042);

        do_write(4'd7, 1'b1, 32'h0000_0001, 32'hDEAD_BEEF);
        read_check("write_alu", 4'd7, 32'hDEAD_BEEF);
        do_write(4'd7, 1'b0, 32'h0000_0001, 32'hDEAD_BEEF);
        read_check("write_data", 4'd7, 32'h0000_0001);

        read_index_a = 4'd2;
        read_index_b = 4'd9;
        issue_valid = 1'b1; issue_index = 4'd2;
        tick();
        read_index_a = 4'd2;
        #1 check("hazard_issue", {31'd0, hazard}, 32'd1);
        issue_valid = 1'b1; issue_index = 4'd2;
        write = 1'b1; write_index = 4'd2; write_data = 32'h0000_0222;
        tick();
        #1 check("hazard_reissue", {31'd0, hazard}, 32'd1);
        write = 1'b1; write_index = 4'd2; write_data = 32'h0000_0333;
`ifdef REGS_FORWARD_EN
        #1 check("fwd_hazard", {31'd0, hazard}, 32'd0);
        check("fwd_data", read_data_a, 32'h0000_0333);
`endif
        tick();
        #1 check("hazard_clear", {31'd0, hazard}, 32'd0);

        prev = retired_writes;
        write = 1'b1; write_index = 4'd4; write_data = 32'h4444_0004;
        write_immediate = 1'b1; write_immediate_type = 2'd0; write_immediate_data = 16'h9999;
        tick();
        read_check("conflict_data", 4'd4, 32'h4444_0004);
        check("conflict_flag", {31'd0, write_conflict}, 32'd1);
        check("conflict_retired", retired_writes, prev + 32'd1);

        for (int n = 0; n < 400; n++) begin
            write                = ($urandom_range(0, 2) == 0);
            write_immediate      = ($urandom_range(0, 2) == 0);
            alu_cycle            = 1'($urandom);
            write_index          = 4'($urandom);
            write_data           = $urandom;
            alu_result_latched   = $urandom;
            write_immediate_data = 16'($urandom);
            write_immediate_type = 2'($urandom);
            issue_valid          = 1'($urandom);
            issue_index          = 4'($urandom);
            read_index_a         = 4'($urandom);
            read_index_b         = 4'($urandom);
            if (n == 200) reset = 1'b1;
            tick();
            reset = 1'b0;
        end

        write = 1'b1; write_index = 4'd6; write_data = 32'h6666_6666;
        write_immediate = 1'b1; issue_valid = 1'b1; issue_index = 4'd6;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        read_index_b = 4'd6;
        read_check("midreset_reg", 4'd6, 32'd0);
        check("midreset_retired", retired_writes, 32'd0);
        check("midreset_conflict", {31'd0, write_conflict}, 32'd0);
        check("midreset_hazard", {31'd0, hazard}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
